// File: rtl/water_pkg.sv
// rtl/water_pkg.sv - shared types, limits and helpers for the water intake tracker
package water_pkg;

  typedef logic [3:0] level_t;
  typedef logic [5:0] total_t;

  localparam total_t TOTAL_MAX = 6'd63;

  typedef enum logic {
    S_SEEK,
    S_TRACK
  } tracker_state_t;

  // Two-digit BCD of a running total, {tens, ones}; totals never exceed 63.
  function automatic logic [7:0] total_to_bcd(input total_t v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 6'd10);
    ones = 4'(v % 6'd10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/level_debouncer.sv
// rtl/level_debouncer.sv - two-flop synchronizer plus candidate/counter level debouncer
// Commit is combinational from registered state so the FSM registers the level on the next edge.
module level_debouncer
  import water_pkg::*;
#(
  parameter int LEVEL_W       = 4,
  parameter int STABLE_CYCLES = 50_000_000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [LEVEL_W-1:0] i_raw_level,
  output logic               o_commit,
  output logic [LEVEL_W-1:0] o_level
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] L_CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [LEVEL_W-1:0] r_sync1;
  logic [LEVEL_W-1:0] r_sync2;
  logic [LEVEL_W-1:0] r_cand;
  logic [CNT_W-1:0]   r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw_level;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt != L_CNT_MAX) begin
        // Holding at the maximum keeps commit asserted for an unchanged level.
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_commit = (r_cnt == L_CNT_MAX) && (r_sync2 == r_cand);
  assign o_level  = r_cand;

endmodule

// File: rtl/water_intake_tracker.sv
// rtl/water_intake_tracker.sv - debounced bottle level, drink events and saturating running total
// Optional WATER_BCD_OUT_EN adds a registered two-digit BCD copy of the total.
module water_intake_tracker
  import water_pkg::*;
#(
  parameter int LEVEL_W       = 4,
  parameter int TOTAL_W       = 6,
  parameter int STABLE_CYCLES = 50_000_000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [LEVEL_W-1:0] i_raw_level,
  input  logic               i_clear_total,
  output logic [LEVEL_W-1:0] o_stable_level,
  output logic               o_stable_valid,
  output logic               o_drink_pulse,
  output logic [LEVEL_W-1:0] o_drink_amount,
  output logic [TOTAL_W-1:0] o_water_drunk,
`ifdef WATER_BCD_OUT_EN
  output logic [7:0]         o_water_drunk_bcd,
`endif
  output logic               o_total_saturated
);

  localparam logic [TOTAL_W-1:0] L_TOTAL_MAX =
    (TOTAL_W == 6) ? TOTAL_W'(TOTAL_MAX) : {TOTAL_W{1'b1}};

  logic               w_commit;
  logic [LEVEL_W-1:0] w_cand;
  logic [LEVEL_W-1:0] w_diff;
  logic [TOTAL_W:0]   w_sum;
  logic [TOTAL_W-1:0] w_total_next;

  tracker_state_t     r_state;
  logic [LEVEL_W-1:0] r_stable_level;
  logic               r_stable_valid;
  logic               r_drink_pulse;
  logic [LEVEL_W-1:0] r_drink_amount;
  logic [TOTAL_W-1:0] r_water_drunk;
  logic               r_total_saturated;

  level_debouncer #(
    .LEVEL_W       (LEVEL_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_debouncer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_raw_level (i_raw_level),
    .o_commit    (w_commit),
    .o_level     (w_cand)
  );

  // One extra sum bit catches the overflow before clamping to the maximum.
  assign w_diff       = r_stable_level - w_cand;
  assign w_sum        = {1'b0, r_water_drunk} + (TOTAL_W + 1)'(w_diff);
  assign w_total_next = (w_sum > {1'b0, L_TOTAL_MAX}) ? L_TOTAL_MAX : w_sum[TOTAL_W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state           <= S_SEEK;
      r_stable_level    <= '0;
      r_stable_valid    <= 1'b0;
      r_drink_pulse     <= 1'b0;
      r_drink_amount    <= '0;
      r_water_drunk     <= '0;
      r_total_saturated <= 1'b0;
    end else begin
      r_drink_pulse  <= 1'b0;
      r_drink_amount <= '0;
      if (w_commit) begin
        case (r_state)
          S_SEEK: begin
            r_stable_level <= w_cand;
            r_stable_valid <= 1'b1;
            r_state        <= S_TRACK;
          end
          S_TRACK: begin
            if (w_cand < r_stable_level) begin
              r_stable_level    <= w_cand;
              r_drink_pulse     <= 1'b1;
              r_drink_amount    <= w_diff;
              r_water_drunk     <= w_total_next;
              r_total_saturated <= (w_total_next == L_TOTAL_MAX);
            end else if (w_cand > r_stable_level) begin
              r_stable_level <= w_cand;
            end
          end
          default: r_state <= S_SEEK;
        endcase
      end
      // Clearing overrides any total update from a drink committed on this edge.
      if (i_clear_total) begin
        r_water_drunk     <= '0;
        r_total_saturated <= 1'b0;
      end
    end
  end

`ifdef WATER_BCD_OUT_EN
  logic [7:0] r_water_drunk_bcd;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_water_drunk_bcd <= 8'h00;
    end else begin
      r_water_drunk_bcd <= total_to_bcd(total_t'(r_water_drunk));
    end
  end

  assign o_water_drunk_bcd = r_water_drunk_bcd;
`endif

  assign o_stable_level    = r_stable_level;
  assign o_stable_valid    = r_stable_valid;
  assign o_drink_pulse     = r_drink_pulse;
  assign o_drink_amount    = r_drink_amount;
  assign o_water_drunk     = r_water_drunk;
  assign o_total_saturated = r_total_saturated;

endmodule

// File: tb/tb_water_intake_tracker.sv
// tb/tb_water_intake_tracker.sv - directed table-driven bench for water_intake_tracker
module tb_water_intake_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] raw_level;
  logic       clear_total;
  logic [3:0] stable_level;
  logic       stable_valid;
  logic       drink_pulse;
  logic [3:0] drink_amount;
  logic [5:0] water_drunk;
  logic       total_saturated;
`ifdef WATER_BCD_OUT_EN
  logic [7:0] water_drunk_bcd;
`endif

  int checks   = 0;
  int failures = 0;

  water_intake_tracker #(
    .LEVEL_W       (4),
    .TOTAL_W       (6),
    .STABLE_CYCLES (4)
  ) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_raw_level       (raw_level),
    .i_clear_total     (clear_total),
    .o_stable_level    (stable_level),
    .o_stable_valid    (stable_valid),
    .o_drink_pulse     (drink_pulse),
    .o_drink_amount    (drink_amount),
    .o_water_drunk     (water_drunk),
`ifdef WATER_BCD_OUT_EN
    .o_water_drunk_bcd (water_drunk_bcd),
`endif
    .o_total_saturated (total_saturated)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] raw;
    logic       clr;
    int         hold;
    logic [3:0] stable;
    logic [5:0] total;
    logic       sat;
    int         pulses;
    logic [3:0] amt;
  } seg_t;

  seg_t tbl [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_stable"}, int'(stable_level), 0);
    check({tag, "_valid"}, int'(stable_valid), 0);
    check({tag, "_pulse"}, int'(drink_pulse), 0);
    check({tag, "_amount"}, int'(drink_amount), 0);
    check({tag, "_total"}, int'(water_drunk), 0);
    check({tag, "_sat"}, int'(total_saturated), 0);
  endtask

  task automatic run_seg(input string tag, input seg_t s);
    int pulses;
    int last_amt;
    int stray;
    pulses    = 0;
    last_amt  = 0;
    stray     = 0;
    raw_level   = s.raw;
    clear_total = s.clr;
    for (int c = 0; c < s.hold; c++) begin
      step();
      clear_total = 1'b0;
      if (drink_pulse) begin
        pulses++;
        last_amt = int'(drink_amount);
      end else if (drink_amount != 4'd0) begin
        stray++;
      end
    end
    check({tag, "_stable"}, int'(stable_level), int'(s.stable));
    check({tag, "_valid"}, int'(stable_valid), 1);
    check({tag, "_total"}, int'(water_drunk), int'(s.total));
    check({tag, "_sat"}, int'(total_saturated), int'(s.sat));
    check({tag, "_pulses"}, pulses, s.pulses);
    check({tag, "_amount"}, last_amt, int'(s.amt));
    check({tag, "_idle_amount"}, stray, 0);
`ifdef WATER_BCD_OUT_EN
    check({tag, "_bcd"}, int'(water_drunk_bcd),
          int'(((s.total / 10) << 4) | (s.total % 10)));
`endif
  endtask

  initial begin
    //            raw    clr   hold stable total  sat   pulses amt
    tbl[0]  = '{4'd9,  1'b0, 10, 4'd9,  6'd3,  1'b0, 1, 4'd3};
    tbl[1]  = '{4'd5,  1'b0, 3,  4'd9,  6'd3,  1'b0, 0, 4'd0};
    tbl[2]  = '{4'd9,  1'b0, 10, 4'd9,  6'd3,  1'b0, 0, 4'd0};
    tbl[3]  = '{4'd15, 1'b0, 10, 4'd15, 6'd3,  1'b0, 0, 4'd0};
    tbl[4]  = '{4'd0,  1'b0, 10, 4'd0,  6'd18, 1'b0, 1, 4'd15};
    tbl[5]  = '{4'd15, 1'b0, 10, 4'd15, 6'd18, 1'b0, 0, 4'd0};
    tbl[6]  = '{4'd0,  1'b0, 10, 4'd0,  6'd33, 1'b0, 1, 4'd15};
    tbl[7]  = '{4'd15, 1'b0, 10, 4'd15, 6'd33, 1'b0, 0, 4'd0};
    tbl[8]  = '{4'd0,  1'b0, 10, 4'd0,  6'd48, 1'b0, 1, 4'd15};
    tbl[9]  = '{4'd15, 1'b0, 10, 4'd15, 6'd48, 1'b0, 0, 4'd0};
    tbl[10] = '{4'd3,  1'b0, 10, 4'd3,  6'd60, 1'b0, 1, 4'd12};
    tbl[11] = '{4'd15, 1'b0, 10, 4'd15, 6'd60, 1'b0, 0, 4'd0};
    tbl[12] = '{4'd8,  1'b0, 10, 4'd8,  6'd63, 1'b1, 1, 4'd7};
    tbl[13] = '{4'd6,  1'b0, 10, 4'd6,  6'd63, 1'b1, 1, 4'd2};

    reset       = 1'b1;
    raw_level   = 4'd12;
    clear_total = 1'b0;
    for (int c = 0; c < 3; c++) step();
    check_reset_state("reset");

    // Baseline commit lands exactly on the 7th edge after reset release.
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      check("baseline_pulse_quiet", int'(drink_pulse), 0);
    end
    check("baseline_valid_early", int'(stable_valid), 0);
    step();
    check("baseline_valid", int'(stable_valid), 1);
    check("baseline_stable", int'(stable_level), 12);
    check("baseline_pulse", int'(drink_pulse), 0);
    check("baseline_total", int'(water_drunk), 0);

    for (int i = 0; i < 14; i++) run_seg($sformatf("seg%0d", i), tbl[i]);

    run_seg("clear_only", '{4'd6, 1'b1, 10, 4'd6, 6'd0, 1'b0, 0, 4'd0});
    run_seg("refill_a", '{4'd15, 1'b0, 10, 4'd15, 6'd0, 1'b0, 0, 4'd0});

    // Clear asserted on the very edge that commits a 4-step drink.
    raw_level = 4'd11;
    for (int c = 0; c < 6; c++) step();
    check("clr_pre_pulse", int'(drink_pulse), 0);
    check("clr_pre_stable", int'(stable_level), 15);
    clear_total = 1'b1;
    step();
    clear_total = 1'b0;
    check("clr_pulse", int'(drink_pulse), 1);
    check("clr_amount", int'(drink_amount), 4);
    check("clr_total", int'(water_drunk), 0);
    check("clr_stable", int'(stable_level), 11);
    step();
    check("clr_pulse_end", int'(drink_pulse), 0);
    check("clr_amount_end", int'(drink_amount), 0);
    check("clr_total_hold", int'(water_drunk), 0);

    run_seg("drop_3", '{4'd3, 1'b0, 10, 4'd3, 6'd8, 1'b0, 1, 4'd8});
    run_seg("refill_b", '{4'd15, 1'b0, 10, 4'd15, 6'd8, 1'b0, 0, 4'd0});
    run_seg("drop_14", '{4'd14, 1'b0, 10, 4'd14, 6'd9, 1'b0, 1, 4'd1});

    // Reset in the middle of a count: the next commit is a fresh baseline.
    raw_level = 4'd2;
    for (int c = 0; c < 3; c++) step();
    reset = 1'b1;
    step();
    check_reset_state("midreset");
    reset = 1'b0;
    for (int c = 0; c < 6; c++) step();
    check("midreset_valid_early", int'(stable_valid), 0);
    step();
    check("midreset_valid", int'(stable_valid), 1);
    check("midreset_stable", int'(stable_level), 2);
    check("midreset_pulse", int'(drink_pulse), 0);
    check("midreset_total", int'(water_drunk), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
